// File: rtl/control_sequencer_if.sv
// Control bus between the instruction sequencer and the datapath.
// The sequencer takes the slave side: it consumes Start/Mem_ready/IR and
// drives every datapath strobe plus the debug state.
interface control_sequencer_if;
    logic        Start;
    logic        Mem_ready;
    logic [31:0] IR;

    logic        PCout;
    logic        MDRout;
    logic        Zlowout;
    logic        ZHighout;
    logic        MARin;
    logic        PCin;
    logic        MDRin;
    logic        IRin;
    logic        Yin;
    logic        IncPC;
    logic        Read;
    logic        ZLowIn;
    logic        ZHighIn;
    logic        HIin;
    logic        LOin;
    logic [4:0]  alu_op;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic        Run;
    logic [3:0]  State;

    modport master (
        output Start, Mem_ready, IR,
        input  PCout, MDRout, Zlowout, ZHighout, MARin, PCin, MDRin, IRin,
               Yin, IncPC, Read, ZLowIn, ZHighIn, HIin, LOin,
               alu_op, Rin, Rout, Run, State
    );

    modport slave (
        input  Start, Mem_ready, IR,
        output PCout, MDRout, Zlowout, ZHighout, MARin, PCin, MDRin, IRin,
               Yin, IncPC, Read, ZLowIn, ZHighIn, HIin, LOin,
               alu_op, Rin, Rout, Run, State
    );
endinterface

// File: rtl/control_sequencer.sv
// Hard-wired control sequencer: fetch (T0-T2), register-to-register
// execute (T3-T6), with a terminal HALT state left only through Clear.
// Strobes are Moore-decoded from the current state and the live IR, so a
// datapath that loads IR at the end of T2 sees the new fields from T3 on.
module control_sequencer (
    input  logic          Clock,
    input  logic          Clear,
    control_sequencer_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    state_t      state_d;
    state_t      state_q;

    logic [4:0]  opcode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic        is_alu;
    logic        is_muldiv;
    logic        is_nop;
    logic        unused_ir_low;

    assign opcode        = bus.IR[31:27];
    assign ra            = bus.IR[26:23];
    assign rb            = bus.IR[22:19];
    assign rc            = bus.IR[18:15];
    assign unused_ir_low = ^bus.IR[14:0];

    // Opcode classification; halt and every unlisted opcode fall through to stop.
    always_comb begin
        is_alu    = 1'b0;
        is_muldiv = 1'b0;
        is_nop    = 1'b0;
        case (opcode)
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010: is_alu    = 1'b1;
            5'b01110, 5'b01111:                     is_muldiv = 1'b1;
            5'b11010:                               is_nop    = 1'b1;
            default: ;
        endcase
    end

    // Next-state selection; Start matters only in IDLE, Mem_ready only in T1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.Start) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (bus.Mem_ready) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (is_alu || is_muldiv) state_d = S_T4;
                else if (is_nop)         state_d = S_T0;
                else                     state_d = S_HALT;
            end
            S_T4:   state_d = S_T5;
            S_T5:   state_d = is_muldiv ? S_T6 : S_T0;
            S_T6:   state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // State register; Clear overrides everything, including Start.
    always_ff @(posedge Clock) begin
        if (Clear) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Moore strobe decode from state and IR fields; unlisted strobes stay 0.
    always_comb begin
        bus.PCout    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.ZHighout = 1'b0;
        bus.MARin    = 1'b0;
        bus.PCin     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.IncPC    = 1'b0;
        bus.Read     = 1'b0;
        bus.ZLowIn   = 1'b0;
        bus.ZHighIn  = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.alu_op   = '0;
        bus.Rin      = '0;
        bus.Rout     = '0;
        bus.Run      = (state_q != S_IDLE) && (state_q != S_HALT);
        bus.State    = state_q;
        case (state_q)
            S_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.PCin  = 1'b1;
            end
            S_T1: begin
                bus.Read  = 1'b1;
                bus.MDRin = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                if (is_alu || is_muldiv) begin
                    bus.Rout = 16'h0001 << rb;
                    bus.Yin  = 1'b1;
                end
            end
            S_T4: begin
                bus.Rout    = 16'h0001 << rc;
                bus.ZLowIn  = 1'b1;
                bus.ZHighIn = is_muldiv;
                bus.alu_op  = opcode;
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                if (is_alu)    bus.Rin  = 16'h0001 << ra;
                if (is_muldiv) bus.LOin = 1'b1;
            end
            S_T6: begin
                bus.ZHighout = 1'b1;
                bus.HIin     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: each instruction is expanded
// into an expected per-cycle timeline (fetch, T1 waits, execute) and the
// DUT's full output vector is compared every cycle.
module tb_control_sequencer;

    logic clk = 1'b0;
    logic clear;

    always #5 clk = ~clk;

    control_sequencer_if bus();

    control_sequencer dut (
        .Clock (clk),
        .Clear (clear),
        .bus   (bus.slave)
    );

    // Strobe bit positions inside the packed comparison word.
    localparam logic [14:0] M_PCOUT    = 15'h0001;
    localparam logic [14:0] M_MDROUT   = 15'h0002;
    localparam logic [14:0] M_ZLOWOUT  = 15'h0004;
    localparam logic [14:0] M_ZHIGHOUT = 15'h0008;
    localparam logic [14:0] M_MARIN    = 15'h0010;
    localparam logic [14:0] M_PCIN     = 15'h0020;
    localparam logic [14:0] M_MDRIN    = 15'h0040;
    localparam logic [14:0] M_IRIN     = 15'h0080;
    localparam logic [14:0] M_YIN      = 15'h0100;
    localparam logic [14:0] M_INCPC    = 15'h0200;
    localparam logic [14:0] M_READ     = 15'h0400;
    localparam logic [14:0] M_ZLOWIN   = 15'h0800;
    localparam logic [14:0] M_ZHIGHIN  = 15'h1000;
    localparam logic [14:0] M_HIIN     = 15'h2000;
    localparam logic [14:0] M_LOIN     = 15'h4000;

    localparam logic [1:0] ACT_NONE   = 2'd0;
    localparam logic [1:0] ACT_WAIT   = 2'd1;
    localparam logic [1:0] ACT_READY  = 2'd2;
    localparam logic [1:0] ACT_LOADIR = 2'd3;

    localparam int K_ALU    = 0;
    localparam int K_MULDIV = 1;
    localparam int K_NOP    = 2;
    localparam int K_STOP   = 3;

    typedef struct packed {
        logic [63:0] w;
        logic [1:0]  act;
    } step_t;

    step_t plan[$];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned instr_no = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got st=%0d strb=%h op=%h rin=%h rout=%h run=%b, expected st=%0d strb=%h op=%h rin=%h rout=%h run=%b",
                     tag, got[56:53], got[52:38], got[37:33], got[32:17], got[16:1], got[0],
                     exp[56:53], exp[52:38], exp[37:33], exp[32:17], exp[16:1], exp[0]);
        end
    endtask

    function automatic logic [63:0] exp_word(input int st, input logic [14:0] strb,
                                             input logic [4:0] op, input logic [15:0] rin,
                                             input logic [15:0] rout);
        logic run;
        logic [3:0] s4;
        run = (st != 0) && (st != 8);
        s4  = 4'(st);
        return {7'd0, s4, strb, op, rin, rout, run};
    endfunction

    function automatic logic [63:0] dut_word();
        logic [14:0] strb;
        strb = {bus.LOin, bus.HIin, bus.ZHighIn, bus.ZLowIn, bus.Read, bus.IncPC, bus.Yin,
                bus.IRin, bus.MDRin, bus.MARin ? 1'b0 : 1'b0, 5'b0} ;
        strb = '0;
        if (bus.PCout)    strb = strb | M_PCOUT;
        if (bus.MDRout)   strb = strb | M_MDROUT;
        if (bus.Zlowout)  strb = strb | M_ZLOWOUT;
        if (bus.ZHighout) strb = strb | M_ZHIGHOUT;
        if (bus.MARin)    strb = strb | M_MARIN;
        if (bus.PCin)     strb = strb | M_PCIN;
        if (bus.MDRin)    strb = strb | M_MDRIN;
        if (bus.IRin)     strb = strb | M_IRIN;
        if (bus.Yin)      strb = strb | M_YIN;
        if (bus.IncPC)    strb = strb | M_INCPC;
        if (bus.Read)     strb = strb | M_READ;
        if (bus.ZLowIn)   strb = strb | M_ZLOWIN;
        if (bus.ZHighIn)  strb = strb | M_ZHIGHIN;
        if (bus.HIin)     strb = strb | M_HIIN;
        if (bus.LOin)     strb = strb | M_LOIN;
        return {7'd0, bus.State, strb, bus.alu_op, bus.Rin, bus.Rout, bus.Run};
    endfunction

    function automatic int op_kind(input logic [4:0] opc);
        case (opc)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: return K_ALU;
            5'd14, 5'd15: return K_MULDIV;
            5'd26:        return K_NOP;
            default:      return K_STOP;
        endcase
    endfunction

    function automatic void push(input int st, input logic [14:0] strb, input logic [4:0] op,
                                 input logic [15:0] rin, input logic [15:0] rout,
                                 input logic [1:0] act);
        step_t s;
        s.w   = exp_word(st, strb, op, rin, rout);
        s.act = act;
        plan.push_back(s);
    endfunction

    // Expected timeline of one instruction from its T0 to its last execute cycle.
    function automatic void build(input logic [31:0] ir, input int waits);
        logic [4:0]  opc;
        logic [15:0] ra_oh, rb_oh, rc_oh;
        int k;
        opc   = ir[31:27];
        ra_oh = 16'h0001 << ir[26:23];
        rb_oh = 16'h0001 << ir[22:19];
        rc_oh = 16'h0001 << ir[18:15];
        k     = op_kind(opc);
        plan.delete();
        push(1, M_PCOUT | M_MARIN | M_INCPC | M_PCIN, 5'd0, '0, '0, ACT_NONE);
        for (int w = 0; w <= waits; w++)
            push(2, M_READ | M_MDRIN, 5'd0, '0, '0, (w < waits) ? ACT_WAIT : ACT_READY);
        push(3, M_MDROUT | M_IRIN, 5'd0, '0, '0, ACT_LOADIR);
        if (k == K_ALU || k == K_MULDIV) begin
            push(4, M_YIN, 5'd0, '0, rb_oh, ACT_NONE);
            push(5, (k == K_MULDIV) ? (M_ZLOWIN | M_ZHIGHIN) : M_ZLOWIN, opc, '0, rc_oh, ACT_NONE);
            if (k == K_ALU) begin
                push(6, M_ZLOWOUT, 5'd0, ra_oh, '0, ACT_NONE);
            end else begin
                push(6, M_ZLOWOUT | M_LOIN, 5'd0, '0, '0, ACT_NONE);
                push(7, M_ZHIGHOUT | M_HIIN, 5'd0, '0, '0, ACT_NONE);
            end
        end else begin
            push(4, '0, 5'd0, '0, '0, ACT_NONE);
        end
    endfunction

    // Cursor convention: each task is entered just after an edge whose cycle
    // has been checked, with the inputs for the next edge still to drive.
    task automatic run_instr(input logic [31:0] ir, input int waits, input int abort_at,
                             output bit aborted);
        aborted = 1'b0;
        instr_no++;
        build(ir, waits);
        for (int i = 0; i < plan.size(); i++) begin
            @(posedge clk); #1;
            check($sformatf("instr%0d_cyc%0d", instr_no, i), dut_word(), plan[i].w);
            if (i == abort_at) begin
                clear     = 1'b1;
                bus.Start = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                clear     = 1'b0;
                bus.Start = 1'b0;
                check($sformatf("instr%0d_abort", instr_no), dut_word(), exp_word(0, '0, '0, '0, '0));
                aborted = 1'b1;
                return;
            end
            bus.Start = 1'($urandom_range(0, 1));
            case (plan[i].act)
                ACT_WAIT:   bus.Mem_ready = 1'b0;
                ACT_READY:  bus.Mem_ready = 1'b1;
                ACT_LOADIR: begin
                    bus.IR        = ir;
                    bus.Mem_ready = 1'($urandom_range(0, 1));
                end
                default:    bus.Mem_ready = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    task automatic halt_phase(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check($sformatf("halt%0d", i), dut_word(), exp_word(8, '0, '0, '0, '0));
            bus.Start     = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.Mem_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_clear(input bit with_start);
        clear     = 1'b1;
        bus.Start = with_start;
        @(posedge clk); #1;
        clear     = 1'b0;
        bus.Start = 1'b0;
        check("clear_idle", dut_word(), exp_word(0, '0, '0, '0, '0));
        @(posedge clk); #1;
        check("idle_hold", dut_word(), exp_word(0, '0, '0, '0, '0));
    endtask

    function automatic logic [31:0] rand_ir();
        logic [4:0] legal [11];
        legal = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd14, 5'd15, 5'd26};
        return {legal[$urandom_range(0, 10)], 27'($urandom)};
    endfunction

    function automatic logic [31:0] rand_stop_ir();
        logic [4:0] opc;
        if ($urandom_range(0, 1) == 0) return {5'b11011, 27'($urandom)};
        opc = 5'($urandom);
        while (op_kind(opc) != K_STOP || opc == 5'b11011) opc = 5'($urandom);
        return {opc, 27'($urandom)};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ab;
        int          n;
        int          w;
        int          abort_at;
        logic [31:0] ir;

        clear         = 1'b1;
        bus.Start     = 1'b0;
        bus.Mem_ready = 1'b1;
        bus.IR        = '0;
        do_clear(1'b0);

        // Directed: or, or with 3 waits, mul, nop, halt.
        bus.Start = 1'b1;
        run_instr(32'h4A920000, 0, -1, ab);
        run_instr(32'h4A920000, 3, -1, ab);
        run_instr(32'h701A0000, 0, -1, ab);
        run_instr(32'hD0000000, 0, -1, ab);
        run_instr(32'hD8000000, 0, -1, ab);
        halt_phase(4);
        do_clear(1'b1);

        // Directed: illegal opcode stops the machine.
        bus.Start = 1'b1;
        run_instr(32'hF8000000, 0, -1, ab);
        halt_phase(3);
        do_clear(1'b0);

        // Directed: Clear during T4 (timeline index 4 with no T1 waits).
        bus.Start = 1'b1;
        run_instr(32'h4A920000, 0, 4, ab);

        // Random programs with T1 waits, ignored Start/Mem_ready noise and
        // occasional Clear at an arbitrary cycle.
        for (int p = 0; p < 25; p++) begin
            bus.Start = 1'b1;
            n  = $urandom_range(1, 6);
            ab = 1'b0;
            for (int i = 0; i < n && !ab; i++) begin
                ir       = rand_ir();
                w        = $urandom_range(0, 3);
                abort_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, w + 7) : -1;
                run_instr(ir, w, abort_at, ab);
            end
            if (!ab) begin
                run_instr(rand_stop_ir(), $urandom_range(0, 2), -1, ab);
                halt_phase($urandom_range(1, 4));
                do_clear(1'($urandom_range(0, 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
